// File: rtl/qos_vc_drain_if.sv
// Bundles the class-FIFO pop side, the merged output stream and the counter
// read port of qos_vc_drain. The drain itself uses the master view; whatever
// sits around it (FIFOs, link transmitter, CSR reader) uses the slave view.
interface qos_vc_drain_if;
  logic        init;
  logic        fifo_empty0;
  logic        fifo_empty1;
  logic        fifo_empty2;
  logic        fifo_empty3;
  logic [11:0] fifo_dataout0;
  logic [11:0] fifo_dataout1;
  logic [11:0] fifo_dataout2;
  logic [11:0] fifo_dataout3;
  logic        popBP0;
  logic        popBP1;
  logic        popBP2;
  logic        popBP3;
  logic        ready_in;
  logic        valid_out;
  logic [11:0] data_out;
  logic        req;
  logic [2:0]  idx;
  logic        valid;
  logic [4:0]  data;
  logic        active_out;
  logic        idle_out;

  modport master (
    input  init, fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
    input  fifo_dataout0, fifo_dataout1, fifo_dataout2, fifo_dataout3,
    input  ready_in, req, idx,
    output popBP0, popBP1, popBP2, popBP3,
    output valid_out, data_out, valid, data, active_out, idle_out
  );

  modport slave (
    output init, fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
    output fifo_dataout0, fifo_dataout1, fifo_dataout2, fifo_dataout3,
    output ready_in, req, idx,
    input  popBP0, popBP1, popBP2, popBP3,
    input  valid_out, data_out, valid, data, active_out, idle_out
  );
endinterface

// File: rtl/qos_vc_drain.sv
// qos_vc_drain: round-robin drain of the four QoS class FIFOs into one
// ready/valid stream, with per-class delivered-word counters and a tag-error
// counter readable through a registered req/idx read port.
module qos_vc_drain (
  input logic            clk,
  input logic            reset,
  qos_vc_drain_if.master bus
);
  localparam int DATA_W = 12;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               pop_en;

  logic [3:0]         empty_vec;
  logic [DATA_W-1:0]  fifo_data [4];

  logic [1:0]         rr_ptr;
  logic               grant_vld;
  logic [1:0]         grant_idx;
  logic [1:0]         cand;
  logic               pop_fire;
  logic [3:0]         pop_vec;

  // a pop issued last cycle whose word is on fifo_dataout this cycle
  logic               pop_vld_p1;
  logic [1:0]         pop_cls_p1;

  logic [DATA_W-1:0]  buf_data [2];
  logic [1:0]         buf_cls  [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         occ;
  logic [1:0]         credit;
  logic               room;
  logic               capture;
  logic               retire;
  logic               tag_err;

  logic [CNT_W-1:0]   cnt [4];
  logic [CNT_W-1:0]   err_cnt;
  logic [CNT_W-1:0]   rd_sel;

  assign empty_vec    = {bus.fifo_empty3, bus.fifo_empty2, bus.fifo_empty1, bus.fifo_empty0};
  assign fifo_data[0] = bus.fifo_dataout0;
  assign fifo_data[1] = bus.fifo_dataout1;
  assign fifo_data[2] = bus.fifo_dataout2;
  assign fifo_data[3] = bus.fifo_dataout3;

  assign bus.valid_out = (occ != 2'd0);
  assign bus.data_out  = bus.valid_out ? buf_data[rd_ptr] : '0;
  assign retire        = bus.valid_out & bus.ready_in;
  assign capture       = pop_vld_p1;
  assign tag_err       = capture && (fifo_data[pop_cls_p1][11:10] != pop_cls_p1);

  // A retiring head frees its slot in the same cycle, which is what keeps the
  // stream at one word per clock with only two buffer entries.
  assign credit = occ + {1'b0, pop_vld_p1};
  assign room   = (credit < 2'd2) | retire;

  assign pop_fire = pop_en & grant_vld & room;
  assign pop_vec  = pop_fire ? (4'b0001 << grant_idx) : 4'b0000;
  assign bus.popBP0 = pop_vec[0];
  assign bus.popBP1 = pop_vec[1];
  assign bus.popBP2 = pop_vec[2];
  assign bus.popBP3 = pop_vec[3];

  assign bus.active_out = (state_q == ST_ACTIVE);
  assign bus.idle_out   = (state_q == ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // Next state and pop enable; init overrides every other transition.
  always_comb begin
    state_d = state_q;
    pop_en  = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!bus.init) state_d = ST_IDLE;
      ST_IDLE: begin
        pop_en = 1'b1;
        if (!(&empty_vec) || (occ != 2'd0)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        pop_en = 1'b1;
        if ((&empty_vec) && !pop_vld_p1 && (occ == 2'd0)) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
    if (bus.init) state_d = ST_INIT;
  end

  // Round-robin search from rr_ptr; the lowest offset with data wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    cand      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (!empty_vec[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Pop stage: remember which class was popped and advance the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_vld_p1 <= 1'b0;
      pop_cls_p1 <= 2'd0;
      rr_ptr     <= 2'd0;
    end else begin
      pop_vld_p1 <= pop_fire;
      if (pop_fire) begin
        pop_cls_p1 <= grant_idx;
        rr_ptr     <= grant_idx + 2'd1;
      end
    end
  end

  // Output buffer pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (retire)  rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, capture} - {1'b0, retire};
    end
  end

  // Output buffer payload; valid_out gating makes a reset of these unnecessary.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_data[wr_ptr] <= fifo_data[pop_cls_p1];
      buf_cls[wr_ptr]  <= pop_cls_p1;
    end
  end

  // Delivered-word counters wrap; the tag-error counter saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      err_cnt <= '0;
    end else if (state_q == ST_INIT) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      err_cnt <= '0;
    end else begin
      if (retire) cnt[buf_cls[rd_ptr]] <= cnt[buf_cls[rd_ptr]] + 5'd1;
      if (tag_err && (err_cnt != 5'd31)) err_cnt <= err_cnt + 5'd1;
    end
  end

  // Read-port select.
  always_comb begin
    rd_sel = '0;
    case (bus.idx)
      3'd0:    rd_sel = cnt[0];
      3'd1:    rd_sel = cnt[1];
      3'd2:    rd_sel = cnt[2];
      3'd3:    rd_sel = cnt[3];
      3'd4:    rd_sel = err_cnt;
      default: rd_sel = '0;
    endcase
  end

  // Registered read response; same-cycle increments show up on the next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.valid <= 1'b0;
      bus.data  <= '0;
    end else begin
      bus.valid <= bus.req;
      bus.data  <= bus.req ? rd_sel : '0;
    end
  end
endmodule

// File: tb/tb_qos_vc_drain.sv
// Bench for qos_vc_drain: emulates the four class FIFOs and checks every cycle
// against a transaction-level model (outstanding-word queue, round-robin
// pointer, counter array), plus directed sequences and read-back tables.
module tb_qos_vc_drain;
  localparam int S_RESET = 0;
  localparam int S_INIT  = 1;
  localparam int S_IDLE  = 2;
  localparam int S_ACT   = 3;

  typedef logic [11:0] wq_t [$];
  typedef struct { logic [11:0] w; int cls; int rdy; } ent_t;
  typedef struct { logic [2:0] idx; int exp; } rd_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  qos_vc_drain_if bus();

  qos_vc_drain dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  wq_t  fq [4];
  ent_t sb [$];
  int   cyc = 0;
  int   m_state;
  int   m_p;
  int   m_cnt [4];
  int   m_err;
  logic prev_req;
  int   prev_exp;

  int          pop_log [$];
  logic [11:0] ret_log [$];
  int          ret_cyc [$];

  logic        s_valid;
  logic [4:0]  s_data;
  logic [3:0]  s_pop;
  logic        s_idle;
  logic        s_vo;
  logic [11:0] s_do;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] get_pop();
    return {bus.popBP3, bus.popBP2, bus.popBP1, bus.popBP0};
  endfunction

  task automatic set_dout(input int i, input logic [11:0] w);
    case (i)
      0: bus.fifo_dataout0 = w;
      1: bus.fifo_dataout1 = w;
      2: bus.fifo_dataout2 = w;
      default: bus.fifo_dataout3 = w;
    endcase
  endtask

  task automatic drive_empty();
    bus.fifo_empty0 = (fq[0].size() == 0);
    bus.fifo_empty1 = (fq[1].size() == 0);
    bus.fifo_empty2 = (fq[2].size() == 0);
    bus.fifo_empty3 = (fq[3].size() == 0);
  endtask

  task automatic push(input int c, input logic [11:0] w);
    fq[c].push_back(w);
    drive_empty();
  endtask

  function automatic int rdval(input logic [2:0] i);
    if (i < 3'd4) return m_cnt[i];
    if (i == 3'd4) return m_err;
    return 0;
  endfunction

  task automatic model_clear();
    sb.delete();
    m_state = S_RESET;
    m_p = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_err = 0;
    prev_req = 1'b0;
    prev_exp = 0;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    ret_log.delete();
    ret_cyc.delete();
  endtask

  // One clock: check at the falling edge, then advance model and FIFOs.
  task automatic tick();
    bit any_ne;
    int nbuf;
    int ninf;
    bit exp_vld;
    bit ret;
    int g;
    int ap;
    int nxt;
    logic [3:0] exp_pop;
    logic [3:0] act_pop;
    ent_t e;
    logic [11:0] w;
    @(negedge clk);
    any_ne = 0;
    for (int i = 0; i < 4; i++) if (fq[i].size() > 0) any_ne = 1;
    nbuf = 0;
    ninf = 0;
    foreach (sb[k]) if (sb[k].rdy <= cyc) nbuf++; else ninf++;
    exp_vld = (nbuf > 0);
    chk("valid_out", bus.valid_out, exp_vld);
    if (exp_vld) chk("data_out", bus.data_out, sb[0].w);
    else if (!reset) chk("data_out_in_reset", bus.data_out, 0);
    ret = exp_vld && bus.ready_in;
    g = -1;
    if (reset && (m_state == S_IDLE || m_state == S_ACT) && (sb.size() - int'(ret) < 2))
      for (int k = 0; k < 4; k++)
        if (g < 0 && fq[(m_p + k) % 4].size() > 0) g = (m_p + k) % 4;
    exp_pop = (g < 0) ? 4'b0000 : (4'b0001 << g);
    act_pop = get_pop();
    chk("popBP", act_pop, exp_pop);
    chk("active_out", bus.active_out, m_state == S_ACT);
    chk("idle_out", bus.idle_out, m_state == S_IDLE);
    chk("rd_valid", bus.valid, prev_req);
    chk("rd_data", bus.data, prev_exp);
    s_valid = bus.valid; s_data = bus.data; s_pop = act_pop;
    s_idle = bus.idle_out; s_vo = bus.valid_out; s_do = bus.data_out;
    ap = -1;
    for (int k = 0; k < 4; k++) if (act_pop[k] && ap < 0) ap = k;
    if (ret) begin
      ret_log.push_back(sb[0].w);
      ret_cyc.push_back(cyc);
    end
    prev_req = bus.req;
    prev_exp = bus.req ? rdval(bus.idx) : 0;
    if (m_state == S_INIT) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_err = 0;
    end else begin
      if (ret) m_cnt[sb[0].cls] = (m_cnt[sb[0].cls] + 1) % 32;
      foreach (sb[k])
        if (sb[k].rdy == cyc + 1 && sb[k].w[11:10] != 2'(sb[k].cls) && m_err < 31) m_err++;
    end
    if (ret) void'(sb.pop_front());
    case (m_state)
      S_RESET: nxt = S_INIT;
      S_INIT:  nxt = S_IDLE;
      S_IDLE:  nxt = (any_ne || nbuf > 0) ? S_ACT : S_IDLE;
      default: nxt = (!any_ne && (nbuf + ninf) == 0) ? S_IDLE : S_ACT;
    endcase
    if (bus.init) nxt = S_INIT;
    if (ap >= 0 && fq[ap].size() > 0) begin
      e.w = fq[ap][0]; e.cls = ap; e.rdy = cyc + 2;
      sb.push_back(e);
      m_p = (ap + 1) % 4;
      pop_log.push_back(ap);
    end
    m_state = nxt;
    if (!reset) model_clear();
    @(posedge clk);
    #1;
    if (ap >= 0 && reset && fq[ap].size() > 0) begin
      w = fq[ap].pop_front();
      set_dout(ap, w);
    end
    drive_empty();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [2:0] i, output logic [4:0] v);
    bus.req = 1'b1; bus.idx = i;
    tick();
    bus.req = 1'b0; bus.idx = 3'd0;
    tick();
    v = s_data;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    run(2);
    reset = 1'b1;
    run(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  v;
    logic [11:0] words [5];
    rd_vec_t     rr_tab [8];
    int          rr_exp [12];
    int          n;

    for (int i = 0; i < 8; i++) begin
      rr_tab[i].idx = 3'(i);
      rr_tab[i].exp = (i < 4) ? 3 : 0;
    end
    for (int i = 0; i < 12; i++) rr_exp[i] = i % 4;

    bus.init = 1'b0; bus.ready_in = 1'b1; bus.req = 1'b0; bus.idx = 3'd0;
    for (int i = 0; i < 4; i++) set_dout(i, 12'h000);
    model_clear();
    drive_empty();

    // Reset values with traffic waiting.
    for (int i = 0; i < 4; i++) push(i, {2'(i), 10'h3F0});
    @(posedge clk);
    #1;
    chk("reset_outputs", {get_pop(), bus.valid_out, bus.data_out, bus.valid, bus.data,
                          bus.active_out, bus.idle_out}, 0);
    run(3);
    chk("reset_no_pop", pop_log.size(), 0);
    reset = 1'b1;
    run(2);
    chk("no_pop_before_idle", pop_log.size(), 0);
    tick();
    chk("idle_after_release", s_idle, 1'b1);
    chk("first_pop", s_pop, 4'b0001);
    run(10);

    // Round-robin at full rate.
    do_reset();
    clear_logs();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) push(i, {2'(i), 10'(j * 16 + i)});
    run(20);
    chk("rr_pop_count", pop_log.size(), 12);
    for (int k = 0; k < 12; k++)
      if (k < pop_log.size()) chk("rr_order", pop_log[k], rr_exp[k]);
    chk("rr_word_count", ret_cyc.size(), 12);
    if (ret_cyc.size() == 12) chk("rr_rate", ret_cyc[11] - ret_cyc[0], 11);
    for (int i = 0; i < 8; i++) begin
      rd(rr_tab[i].idx, v);
      chk("rr_readback", v, rr_tab[i].exp);
    end

    // Backpressure on a single class.
    do_reset();
    clear_logs();
    bus.ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      words[k] = {2'd2, 10'(10'h100 + k)};
      push(2, words[k]);
    end
    run(6);
    chk("bp_two_pops", pop_log.size(), 2);
    chk("bp_valid_held", s_vo, 1'b1);
    chk("bp_head_stable", s_do, words[0]);
    bus.ready_in = 1'b1;
    run(10);
    chk("bp_all_popped", pop_log.size(), 5);
    chk("bp_all_out", ret_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < ret_log.size()) chk("bp_order", ret_log[k], words[k]);

    // Tag mismatch is counted but still forwarded.
    do_reset();
    clear_logs();
    push(1, 12'hC05);
    run(5);
    chk("tag_fwd_count", ret_log.size(), 1);
    if (ret_log.size() > 0) chk("tag_fwd_word", ret_log[0], 12'hC05);
    rd(3'd4, v); chk("tag_err_cnt", v, 1);
    rd(3'd1, v); chk("tag_cls_cnt", v, 1);

    // Counter wrap and error saturation.
    do_reset();
    for (int k = 0; k < 33; k++) push(3, {2'd3, 10'(k)});
    run(40);
    rd(3'd3, v); chk("cnt_wrap", v, 1);
    for (int k = 0; k < 40; k++) push(0, {2'd1, 10'(k)});
    run(46);
    rd(3'd4, v); chk("err_sat", v, 31);
    rd(3'd0, v); chk("cnt0_wrap", v, 8);

    // init mid-stream: pops stop, buffer drains, counters clear.
    do_reset();
    clear_logs();
    for (int k = 0; k < 8; k++) push(0, {2'd0, 10'(10'h200 + k)});
    run(3);
    bus.init = 1'b1;
    tick();
    n = pop_log.size();
    run(6);
    chk("init_no_pop", pop_log.size(), n);
    chk("init_drained", s_vo, 1'b0);
    rd(3'd0, v); chk("init_cnt_clear", v, 0);
    bus.init = 1'b0;
    run(14);

    // Reset with two words buffered discards them.
    do_reset();
    clear_logs();
    bus.ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      words[k] = {2'd3, 10'(10'h0A0 + k)};
      push(3, words[k]);
    end
    run(5);
    reset = 1'b0;
    model_clear();
    #1;
    chk("rst_valid_drop", bus.valid_out, 1'b0);
    chk("rst_data_drop", bus.data_out, 0);
    run(2);
    reset = 1'b1;
    bus.ready_in = 1'b1;
    run(12);
    chk("rst_out_count", ret_log.size(), 2);
    if (ret_log.size() == 2) begin
      chk("rst_first_new", ret_log[0], words[2]);
      chk("rst_second_new", ret_log[1], words[3]);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 2000; t++) begin
      int c;
      c = $urandom_range(0, 3);
      if (fq[c].size() < 6 && $urandom_range(0, 2) == 0)
        push(c, {($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'(c), 10'($urandom)});
      bus.ready_in = ($urandom_range(0, 3) != 0);
      bus.req = 1'($urandom);
      bus.idx = 3'($urandom);
      bus.init = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.init = 1'b0; bus.req = 1'b0; bus.ready_in = 1'b1;
    run(40);
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), v);
      chk("rand_readback", v, rdval(3'(i)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
